tpu_host_seq: RTL and testbench
===============================

TPU_HOST_SEQ -- requirements
Module: tpu_host_seq

Interface
REQ-001 SHALL have parameters: N, default 4, matrix dimension; DATA_W, default 8, A/B element width; SUM_W, default 32, C element width; TPU_BASE, default 16'h0000, accelerator register base; ID_VALUE, default 32'h5450_0001, expected ID word; POLL_MAX, default 1024, maximum STATUS polls per job.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have job ports: job_start  in  1  start request; job_busy  out  1  job in progress; job_done  out  1  one-cycle completion pulse; job_err  out  1  sticky error flag.
REQ-004 SHALL have an operand stream: in_valid  in  1; in_ready  out  1; in_data  in  DATA_W  A elements row-major, then B elements row-major.
REQ-005 SHALL have a result stream: out_valid  out  1; out_ready  in  1; out_data  out  SUM_W  C elements row-major.
REQ-006 SHALL have an MMIO initiator port: mmio_wr  out  1; mmio_rd  out  1; mmio_addr  out  16; mmio_wdata  out  32; mmio_wstrb  out  4; mmio_rdata  in  32  combinational read data; mmio_ready  in  1  transaction accepted this cycle.

Function
REQ-007 SHALL issue at most one MMIO transaction per cycle, never assert mmio_wr and mmio_rd together, and hold each transaction stable until the cycle mmio_ready=1.
REQ-008 SHALL sample mmio_rdata in the cycle mmio_rd && mmio_ready.
REQ-009 SHALL use states IDLE, CHK_ID, LOAD_A, LOAD_B, START, POLL, READ_C, CLEAR, ERR.
REQ-010 IDLE: job_start=1 SHALL go to CHK_ID (or LOAD_A when ID check is compiled out) and set job_busy=1 on the next cycle; job_start SHALL be ignored while job_busy=1.
REQ-011 CHK_ID: read TPU_BASE+0x0; mismatch with ID_VALUE SHALL go to ERR; match SHALL go to LOAD_A.
REQ-012 LOAD_A/LOAD_B: element i (0..N*N-1) SHALL be written to TPU_BASE+0x100+i or TPU_BASE+0x200+i, with wdata {zero, in_data} and wstrb 4'b0001.
REQ-013 in_ready SHALL be 1 only in LOAD_A/LOAD_B with mmio_ready=1; mmio_wr SHALL equal in_valid in those states; an element is consumed on in_valid && in_ready.
REQ-014 After element N*N-1 of B, START SHALL write 32'h1 to TPU_BASE+0x8, wstrb 4'b1111, then go to POLL.
REQ-015 POLL: read TPU_BASE+0xC every accepted cycle; bit1=1 SHALL go to READ_C; the poll counter SHALL increment per accepted read; reaching POLL_MAX reads without bit1 SHALL go to ERR.
REQ-016 READ_C: read TPU_BASE+0x300+i into an output register, assert out_valid, and issue no further read until out_valid && out_ready; after element N*N-1 is accepted, go to CLEAR.
REQ-017 CLEAR: write 32'h2 to TPU_BASE+0x8, then go to IDLE with job_busy=0 and a single-cycle job_done pulse.
REQ-018 ERR: job_err=1 and job_busy=0, with no MMIO traffic; job_start SHALL clear job_err and restart as in REQ-010.
REQ-019 Element and poll counters SHALL be sized $clog2(N*N+1) and $clog2(POLL_MAX+1) and SHALL reset to 0 on every state entry.

Reset
REQ-020 rst_n=0 SHALL immediately force IDLE, drive all outputs to 0, and clear all counters and out_data, including mid-transaction; no MMIO strobe may be asserted while rst_n=0.

Configuration
REQ-021 The macro TPU_HOST_SEQ_ID_CHECK_EN SHALL control the ID check: when defined, CHK_ID is included; when undefined, CHK_ID is removed and IDLE goes directly to LOAD_A.

Structure
REQ-022 The register offsets (0x0, 0x4, 0x8, 0xC, 0x100, 0x200, 0x300), the CTRL bit positions (start=0, clear_done=1), the STATUS bit positions (busy=0, done=1), and the state enum SHALL live in a shared package, tpu_pkg, also used by the accelerator register block.
REQ-023 No sub-module is needed; a single module is sufficient.

Verification
REQ-024 With A=identity and B=1..16 against the real accelerator, the bench SHALL see out_data 1..16 in order, job_done pulsing once, and STATUS done=0 afterwards.
REQ-025 With in_valid toggling every other cycle and out_ready low 3 of every 4 cycles, the bench SHALL see the same 16 results, no element dropped or duplicated, and out_data stable while stalled.
REQ-026 With a stub responder that never sets done and POLL_MAX=8, the bench SHALL see exactly 8 STATUS reads, then job_err=1 and job_busy=0.
REQ-027 With ID_CHECK_EN defined and the stub returning ID 32'hDEAD_BEEF, the bench SHALL see job_err=1 after one read and no writes.
REQ-028 Asserting rst_n=0 at the 5th A write SHALL drop all strobes immediately; a new job after reset SHALL complete correctly.
REQ-029 A job_start pulse during POLL SHALL be ignored, with no restart and an unchanged result.

Source files
------------

// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU accelerator register map. Used by the host
// sequencer (tpu_host_seq) and by the accelerator register block.
//   - register offsets relative to the accelerator base address
//   - CTRL / STATUS bit positions
//   - host sequencer state enumeration
//   - ctrl_bit(): builds a one-hot CTRL write word from a bit position
// ---------------------------------------------------------------------------
package tpu_pkg;

  // Register map offsets
  localparam logic [15:0] REG_ID      = 16'h0000;
  localparam logic [15:0] REG_VERSION = 16'h0004;
  localparam logic [15:0] REG_CTRL    = 16'h0008;
  localparam logic [15:0] REG_STATUS  = 16'h000C;
  localparam logic [15:0] MEM_A       = 16'h0100;
  localparam logic [15:0] MEM_B       = 16'h0200;
  localparam logic [15:0] MEM_C       = 16'h0300;

  // CTRL bit positions
  localparam int unsigned CTRL_START_BIT      = 32'd0;
  localparam int unsigned CTRL_CLEAR_DONE_BIT = 32'd1;

  // STATUS bit positions
  localparam int unsigned STATUS_BUSY_BIT = 32'd0;
  localparam int unsigned STATUS_DONE_BIT = 32'd1;

  // Host sequencer states
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CHK_ID = 4'd1,
    LOAD_A = 4'd2,
    LOAD_B = 4'd3,
    START  = 4'd4,
    POLL   = 4'd5,
    READ_C = 4'd6,
    CLEAR  = 4'd7,
    ERR    = 4'd8
  } tpu_state_e;

  // One-hot CTRL word with only bit 'pos' set
  function automatic logic [31:0] ctrl_bit(input int unsigned pos);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[pos[4:0]] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/tpu_host_seq.sv
// ---------------------------------------------------------------------------
// tpu_host_seq
// Host-side job sequencer for the TPU matrix accelerator. For each job it
// (optionally) checks the accelerator ID, streams N*N A elements and N*N B
// elements into the accelerator memories, starts the multiply, polls STATUS
// until done, streams the N*N C results out, and clears the done flag.
//
// Compile-time option: define TPU_HOST_SEQ_ID_CHECK_EN to read and compare
// the ID register before each job; without it a job begins at LOAD_A.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   job_start                     start request (ignored while job_busy)
//   job_busy / job_done / job_err job in progress / 1-cycle done / sticky error
//   in_valid, in_ready, in_data   operand stream: A row-major then B row-major
//   out_valid, out_ready, out_data result stream: C row-major
//   mmio_wr, mmio_rd, mmio_addr,  MMIO initiator; a transaction is held until
//   mmio_wdata, mmio_wstrb,       the cycle mmio_ready=1, read data is sampled
//   mmio_rdata, mmio_ready        in that same cycle
// ---------------------------------------------------------------------------
module tpu_host_seq
  import tpu_pkg::*;
#(
  parameter int          N        = 4,
  parameter int          DATA_W   = 8,
  parameter int          SUM_W    = 32,
  parameter logic [15:0] TPU_BASE = 16'h0000,
  parameter logic [31:0] ID_VALUE = 32'h5450_0001,
  parameter int          POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_start,
  output logic              job_busy,
  output logic              job_done,
  output logic              job_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_data,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [15:0]       mmio_addr,
  output logic [31:0]       mmio_wdata,
  output logic [3:0]        mmio_wstrb,
  input  logic [31:0]       mmio_rdata,
  input  logic              mmio_ready
);

  localparam int ELEMS = N * N;
  localparam int EW    = $clog2(ELEMS + 1);
  localparam int PW    = $clog2(POLL_MAX + 1);

  localparam logic [EW-1:0] LAST_ELEM = EW'(ELEMS - 1);
  localparam logic [PW-1:0] LAST_POLL = PW'(POLL_MAX - 1);

  // Without the ID check nothing ever enters CHK_ID, so its logic is pruned.
`ifdef TPU_HOST_SEQ_ID_CHECK_EN
  localparam tpu_state_e FIRST_STATE = CHK_ID;
`else
  localparam tpu_state_e FIRST_STATE = LOAD_A;
`endif

  tpu_state_e       state_r;
  logic [EW-1:0]    elem_cnt_r;
  logic [PW-1:0]    poll_cnt_r;
  logic             job_busy_r;
  logic             job_done_r;
  logic             job_err_r;
  logic             out_valid_r;
  logic [SUM_W-1:0] out_data_r;

  logic             wr_s;
  logic             rd_s;
  logic [15:0]      addr_s;
  logic [31:0]      wdata_s;
  logic [3:0]       wstrb_s;
  logic             in_ready_s;
  logic [15:0]      elem_off_s;

  assign elem_off_s = 16'(elem_cnt_r);

  // MMIO request decode from the current state and element index
  always_comb begin
    wr_s       = 1'b0;
    rd_s       = 1'b0;
    addr_s     = 16'h0000;
    wdata_s    = 32'h0000_0000;
    wstrb_s    = 4'b0000;
    in_ready_s = 1'b0;
    case (state_r)
      CHK_ID: begin
        rd_s   = 1'b1;
        addr_s = TPU_BASE + REG_ID;
      end
      LOAD_A: begin
        // Each operand element maps 1:1 onto a write, so the write strobe
        // follows in_valid and acceptance is the bus handshake.
        wr_s       = in_valid;
        in_ready_s = mmio_ready;
        addr_s     = TPU_BASE + MEM_A + elem_off_s;
        wdata_s    = 32'(in_data);
        wstrb_s    = 4'b0001;
      end
      LOAD_B: begin
        wr_s       = in_valid;
        in_ready_s = mmio_ready;
        addr_s     = TPU_BASE + MEM_B + elem_off_s;
        wdata_s    = 32'(in_data);
        wstrb_s    = 4'b0001;
      end
      START: begin
        wr_s    = 1'b1;
        addr_s  = TPU_BASE + REG_CTRL;
        wdata_s = ctrl_bit(CTRL_START_BIT);
        wstrb_s = 4'b1111;
      end
      POLL: begin
        rd_s   = 1'b1;
        addr_s = TPU_BASE + REG_STATUS;
      end
      READ_C: begin
        // The output register holds one element; fetch the next only once
        // the current one has been taken.
        rd_s   = ~out_valid_r;
        addr_s = TPU_BASE + MEM_C + elem_off_s;
      end
      CLEAR: begin
        wr_s    = 1'b1;
        addr_s  = TPU_BASE + REG_CTRL;
        wdata_s = ctrl_bit(CTRL_CLEAR_DONE_BIT);
        wstrb_s = 4'b1111;
      end
      default: begin
        wr_s = 1'b0;
      end
    endcase
  end

  // Job sequencer: state, counters and registered job/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      elem_cnt_r  <= '0;
      poll_cnt_r  <= '0;
      job_busy_r  <= 1'b0;
      job_done_r  <= 1'b0;
      job_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      job_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (job_start) begin
            state_r    <= FIRST_STATE;
            job_busy_r <= 1'b1;
            elem_cnt_r <= '0;
            poll_cnt_r <= '0;
          end
        end
        CHK_ID: begin
          if (mmio_ready) begin
            elem_cnt_r <= '0;
            poll_cnt_r <= '0;
            if (mmio_rdata == ID_VALUE) begin
              state_r <= LOAD_A;
            end else begin
              state_r    <= ERR;
              job_err_r  <= 1'b1;
              job_busy_r <= 1'b0;
            end
          end
        end
        LOAD_A: begin
          if (in_valid && in_ready_s) begin
            if (elem_cnt_r == LAST_ELEM) begin
              state_r    <= LOAD_B;
              elem_cnt_r <= '0;
              poll_cnt_r <= '0;
            end else begin
              elem_cnt_r <= elem_cnt_r + EW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_valid && in_ready_s) begin
            if (elem_cnt_r == LAST_ELEM) begin
              state_r    <= START;
              elem_cnt_r <= '0;
              poll_cnt_r <= '0;
            end else begin
              elem_cnt_r <= elem_cnt_r + EW'(1);
            end
          end
        end
        START: begin
          if (mmio_ready) begin
            state_r    <= POLL;
            elem_cnt_r <= '0;
            poll_cnt_r <= '0;
          end
        end
        POLL: begin
          if (mmio_ready) begin
            if (mmio_rdata[STATUS_DONE_BIT]) begin
              state_r    <= READ_C;
              elem_cnt_r <= '0;
              poll_cnt_r <= '0;
            end else if (poll_cnt_r == LAST_POLL) begin
              // POLL_MAX reads have now been made without seeing done
              state_r    <= ERR;
              job_err_r  <= 1'b1;
              job_busy_r <= 1'b0;
              elem_cnt_r <= '0;
              poll_cnt_r <= '0;
            end else begin
              poll_cnt_r <= poll_cnt_r + PW'(1);
            end
          end
        end
        READ_C: begin
          if (out_valid_r) begin
            if (out_ready) begin
              out_valid_r <= 1'b0;
              if (elem_cnt_r == LAST_ELEM) begin
                state_r    <= CLEAR;
                elem_cnt_r <= '0;
                poll_cnt_r <= '0;
              end else begin
                elem_cnt_r <= elem_cnt_r + EW'(1);
              end
            end
          end else if (mmio_ready) begin
            out_data_r  <= mmio_rdata[SUM_W-1:0];
            out_valid_r <= 1'b1;
          end
        end
        CLEAR: begin
          if (mmio_ready) begin
            state_r    <= IDLE;
            job_busy_r <= 1'b0;
            job_done_r <= 1'b1;
            elem_cnt_r <= '0;
            poll_cnt_r <= '0;
          end
        end
        ERR: begin
          if (job_start) begin
            state_r    <= FIRST_STATE;
            job_err_r  <= 1'b0;
            job_busy_r <= 1'b1;
            elem_cnt_r <= '0;
            poll_cnt_r <= '0;
          end
        end
        default: begin
          state_r    <= IDLE;
          job_busy_r <= 1'b0;
          elem_cnt_r <= '0;
          poll_cnt_r <= '0;
        end
      endcase
    end
  end

  assign job_busy   = job_busy_r;
  assign job_done   = job_done_r;
  assign job_err    = job_err_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign in_ready   = in_ready_s;
  assign mmio_wr    = wr_s;
  assign mmio_rd    = rd_s;
  assign mmio_addr  = addr_s;
  assign mmio_wdata = wdata_s;
  assign mmio_wstrb = wstrb_s;

endmodule

// File: tb/tb_tpu_host_seq.sv
// ---------------------------------------------------------------------------
// tb_tpu_host_seq
// Scoreboard bench for tpu_host_seq. A behavioural accelerator answers the
// MMIO port; expected C values are queued when a job is issued and a
// separate monitor pops and compares them as results are handed over.
// ---------------------------------------------------------------------------
module tb_tpu_host_seq;

  localparam int          N        = 4;
  localparam int          NN       = N * N;
  localparam int          DATA_W   = 8;
  localparam int          SUM_W    = 32;
  localparam logic [15:0] BASE     = 16'h1000;
  localparam logic [31:0] ID_WORD  = 32'h5450_0001;
  localparam int          POLL_MAX = 8;

  typedef logic [31:0] vec_t [NN];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              job_start = 1'b0;
  logic              job_busy, job_done, job_err;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SUM_W-1:0]  out_data;
  logic              mmio_wr, mmio_rd;
  logic [15:0]       mmio_addr;
  logic [31:0]       mmio_wdata;
  logic [3:0]        mmio_wstrb;
  logic [31:0]       mmio_rdata;
  logic              mmio_ready = 1'b0;

  always #5 clk = ~clk;

  tpu_host_seq #(
    .N(N), .DATA_W(DATA_W), .SUM_W(SUM_W), .TPU_BASE(BASE),
    .ID_VALUE(ID_WORD), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_busy(job_busy),
    .job_done(job_done), .job_err(job_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .mmio_wr(mmio_wr),
    .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Plain matrix product element: C[i][j] = sum_k A[i][k] * B[k][j]
  function automatic logic [31:0] matmul_elem(input vec_t a, input vec_t b, input int idx);
    logic [31:0] s;
    s = 32'h0;
    for (int k = 0; k < N; k++)
      s = s + a[(idx / N) * N + k] * b[k * N + (idx % N)];
    return s;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // ---------------- behavioural accelerator ----------------
  vec_t        acc_a, acc_b, acc_c;
  logic        acc_busy = 1'b0;
  logic        acc_done = 1'b0;
  int          acc_delay = 0;
  logic        hang_mode = 1'b0;
  logic [31:0] id_word = ID_WORD;
  int          status_reads = 0, id_reads = 0, writes = 0, start_writes = 0;
  logic [15:0] rd_off;
  logic [15:0] wr_off;

  always_comb begin
    rd_off     = mmio_addr - BASE;
    mmio_rdata = 32'h0;
    if (rd_off == 16'h0000)
      mmio_rdata = id_word;
    else if (rd_off == 16'h000C)
      mmio_rdata = {30'h0, acc_done, acc_busy};
    else if (rd_off >= 16'h0300 && rd_off < 16'h0310)
      mmio_rdata = acc_c[rd_off[3:0]];
  end

  assign wr_off = mmio_addr - BASE;

  // Transactions seen mid-cycle are the ones accepted at the next rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_busy && !hang_mode) begin
        if (acc_delay == 0) begin
          acc_busy <= 1'b0;
          acc_done <= 1'b1;
        end else begin
          acc_delay <= acc_delay - 1;
        end
      end
      if (mmio_wr && mmio_ready) begin
        writes <= writes + 1;
        if (wr_off >= 16'h0100 && wr_off < 16'h0110)
          acc_a[wr_off[3:0]] <= apply_strb(acc_a[wr_off[3:0]], mmio_wdata, mmio_wstrb);
        else if (wr_off >= 16'h0200 && wr_off < 16'h0210)
          acc_b[wr_off[3:0]] <= apply_strb(acc_b[wr_off[3:0]], mmio_wdata, mmio_wstrb);
        else if (wr_off == 16'h0008 && mmio_wstrb[0]) begin
          if (mmio_wdata[0]) begin
            start_writes <= start_writes + 1;
            for (int i = 0; i < NN; i++) acc_c[i] <= matmul_elem(acc_a, acc_b, i);
            acc_busy  <= 1'b1;
            acc_done  <= 1'b0;
            acc_delay <= int'($urandom_range(0, 4));
          end else if (mmio_wdata[1]) begin
            acc_done <= 1'b0;
          end
        end
      end
      if (mmio_rd && mmio_ready) begin
        if (rd_off == 16'h000C) status_reads <= status_reads + 1;
        if (rd_off == 16'h0000) id_reads <= id_reads + 1;
      end
    end
  end

  // ---------------- random handshake drivers ----------------
  int or_mode = 2;
  int cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mmio_ready = ($urandom_range(0, 3) != 0);
      case (or_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = ((cyc % 4) == 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [31:0] exp_q[$];
  int          done_cnt = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_data;
  logic        mm_pend = 1'b0;
  logic [53:0] mm_prev;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_valid = 1'b0;
        mm_pend    = 1'b0;
      end else begin
        if (job_done) done_cnt++;
        if (out_valid) begin
          if (hold_valid) check("out_data_stable", out_data, hold_data);
          if (out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_result", int'(out_data), -1);
            else check("out_data", out_data, exp_q.pop_front());
            hold_valid = 1'b0;
          end else begin
            hold_valid = 1'b1;
            hold_data  = out_data;
          end
        end else begin
          if (hold_valid) fail_now("out_valid_dropped", 0, 1);
          hold_valid = 1'b0;
        end
        if (mmio_wr && mmio_rd) fail_now("mmio_wr_and_rd", 1, 0);
        if (mm_pend) check("mmio_held", {10'h0, mm_prev[53:32]} ^ 32'h0, {10'h0, mmio_wr, mmio_rd, mmio_addr, mmio_wstrb});
        if (mm_pend && mmio_wr) check("mmio_wdata_held", mmio_wdata, mm_prev[31:0]);
        mm_pend = (mmio_wr || mmio_rd) && !mmio_ready;
        mm_prev = {mmio_wr, mmio_rd, mmio_addr, mmio_wstrb, mmio_wdata};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t a_m, b_m;

  task automatic push_expected();
    for (int i = 0; i < NN; i++) exp_q.push_back(matmul_elem(a_m, b_m, i));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    job_start = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  task automatic feed(input int vmode, input int abort_at, output bit aborted);
    int idx, guard;
    bit acc, last_acc;
    idx = 0; guard = 0; aborted = 1'b0; last_acc = 1'b0;
    while (idx < 2 * NN && guard < 4000) begin
      if (!in_valid) begin
        case (vmode)
          0:       in_valid = 1'($urandom_range(0, 1));
          1:       in_valid = !last_acc;
          default: in_valid = 1'b1;
        endcase
      end
      in_data = (idx < NN) ? a_m[idx][7:0] : b_m[idx - NN][7:0];
      @(negedge clk);
      if (abort_at == idx && in_valid && mmio_wr) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_mmio_wr", mmio_wr, 1'b0);
        check("rst_mmio_rd", mmio_rd, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_job_busy", job_busy, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        aborted = 1'b1;
        in_valid = 1'b0;
        return;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      last_acc = acc;
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (idx < 2 * NN) fail_now("feed_timeout", idx, 2 * NN);
  endtask

  task automatic wait_end(input int d0, input bit poke);
    bit poked;
    int n;
    poked = 1'b0;
    n = 0;
    while (n < 3000 && done_cnt == d0 && !job_err) begin
      @(posedge clk); #1;
      n++;
      job_start = 1'b0;
      if (poke && !poked && mmio_rd && mmio_addr == BASE + 16'h000C) begin
        job_start = 1'b1;
        poked = 1'b1;
      end
    end
    job_start = 1'b0;
    if (n >= 3000) fail_now("job_timeout", n, 3000);
  endtask

  task automatic run_job(input int vmode, input int omode, input bit poke);
    int d0, s0;
    bit ab;
    d0 = done_cnt;
    s0 = start_writes;
    push_expected();
    or_mode = omode;
    pulse_start();
    check("busy_on_start", job_busy, 1'b1);
    check("err_clear_on_start", job_err, 1'b0);
    feed(vmode, -1, ab);
    wait_end(d0, poke);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_job", job_busy, 1'b0);
    check("err_after_job", job_err, 1'b0);
    check("results_left", exp_q.size(), 0);
    check("status_done_after", acc_done, 1'b0);
    check("start_writes", start_writes - s0, 1);
    exp_q.delete();
  endtask

  task automatic random_mats();
    for (int i = 0; i < NN; i++) begin
      a_m[i] = 32'($urandom_range(0, 255));
      b_m[i] = 32'($urandom_range(0, 255));
    end
  endtask

  initial begin
    bit ab;
    int r0, w0, i0;

    // Reset state
    #12;
    check("reset_mmio_wr", mmio_wr, 1'b0);
    check("reset_mmio_rd", mmio_rd, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_busy", job_busy, 1'b0);
    check("reset_done", job_done, 1'b0);
    check("reset_err", job_err, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", job_busy, 1'b0);
    check("idle_mmio_rd", mmio_rd, 1'b0);

    // Identity A, B = 1..16, free-flowing handshakes
    for (int i = 0; i < NN; i++) begin
      a_m[i] = ((i / N) == (i % N)) ? 32'd1 : 32'd0;
      b_m[i] = 32'(i + 1);
    end
    run_job(2, 2, 1'b0);

    // Same job with sparse in_valid and out_ready low 3 of 4 cycles
    run_job(1, 1, 1'b0);

    // Random jobs, random handshakes
    for (int t = 0; t < 3; t++) begin
      random_mats();
      run_job(0, 0, 1'b0);
    end

    // job_start during POLL must be ignored
    random_mats();
    run_job(2, 0, 1'b1);

    // Accelerator never finishes: exactly POLL_MAX STATUS reads, then error
    hang_mode = 1'b1;
    random_mats();
    r0 = status_reads;
    pulse_start();
    feed(2, -1, ab);
    wait_end(done_cnt, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("hang_status_reads", status_reads - r0, POLL_MAX);
    check("hang_err", job_err, 1'b1);
    check("hang_busy", job_busy, 1'b0);
    check("hang_out_valid", out_valid, 1'b0);
    hang_mode = 1'b0;

    // Restart from error
    random_mats();
    run_job(0, 0, 1'b0);

`ifdef TPU_HOST_SEQ_ID_CHECK_EN
    // Wrong ID: one read, no writes, error
    id_word = 32'hDEAD_BEEF;
    i0 = id_reads;
    w0 = writes;
    pulse_start();
    wait_end(done_cnt, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("badid_err", job_err, 1'b1);
    check("badid_busy", job_busy, 1'b0);
    check("badid_reads", id_reads - i0, 1);
    check("badid_writes", writes - w0, 0);
    id_word = ID_WORD;
    random_mats();
    run_job(2, 2, 1'b0);
`else
    i0 = 0;
    w0 = 0;
`endif

    // Reset at the 5th A write, then a clean job
    random_mats();
    or_mode = 2;
    pulse_start();
    feed(2, 4, ab);
    check("abort_reached", ab, 1'b1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_reset_busy", job_busy, 1'b0);
    random_mats();
    run_job(0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
